serial_add_ctrl: RTL and testbench

Bit-serial N-bit adder controller. It time-shares a single instance of the existing full_adder cell across WIDTH cycles, adding one bit per cycle from the LSB up. It uses a start/busy/done handshake and is the sequencing layer that turns the 1-bit full_adder datapath into a multi-bit adder with minimal area.

---
 rtl/serial_add_ctrl.sv | 160 ++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder controller.
// A single full_adder cell is reused once per cycle, LSB first, under a
// start/busy/done handshake. {c_out, sum} = a + b + c_in (unsigned).
// Optional feature macro: SERIAL_ADD_OVF_EN adds a registered signed
// overflow output (ovf) captured together with sum.

// 1-bit full adder cell shared across all bit positions.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] op_a_reg;
    logic [WIDTH-1:0] op_b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             c_out_reg;

    logic [WIDTH-1:0] op_a_shift;
    logic [WIDTH-1:0] op_b_shift;
    logic             fa_sum;
    logic             fa_c_out;
    logic             last_bit;

    // Bit 0 of each operand register plus the carry FF feed the shared cell.
    full_adder u_fa (
        .a     (op_a_reg[0]),
        .b     (op_b_reg[0]),
        .c_in  (carry_reg),
        .sum   (fa_sum),
        .c_out (fa_c_out)
    );

    // Logical right shift of the operand registers (zero enters the MSB).
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign op_a_shift[gi] = op_a_reg[gi+1];
            assign op_b_shift[gi] = op_b_reg[gi+1];
        end
    endgenerate
    assign op_a_shift[WIDTH-1] = 1'b0;
    assign op_b_shift[WIDTH-1] = 1'b0;

    assign last_bit = (cnt_reg == LAST_BIT);

    // Next-state decode: IDLE -> RUN on start, RUN -> DONE after the MSB, DONE -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_bit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath: operand capture on start, one bit per RUN cycle, result load on the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        op_a_reg  <= a;
                        op_b_reg  <= b;
                        carry_reg <= c_in;
                        cnt_reg   <= '0;
                    end
                end
                S_RUN: begin
                    op_a_reg  <= op_a_shift;
                    op_b_reg  <= op_b_shift;
                    acc_reg   <= {fa_sum, acc_reg[WIDTH-1:1]};
                    carry_reg <= fa_c_out;
                    if (last_bit) begin
                        // Counter parks at zero so it never exceeds WIDTH-1.
                        cnt_reg   <= '0;
                        sum_reg   <= {fa_sum, acc_reg[WIDTH-1:1]};
                        c_out_reg <= fa_c_out;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_reg;

    // Signed overflow: carry into the MSB (carry FF on the last bit) XOR carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == S_RUN && last_bit) begin
            ovf_reg <= carry_reg ^ fa_c_out;
        end
    end

    assign ovf = ovf_reg;
`endif

    assign busy  = (state_reg == S_RUN);
    assign done  = (state_reg == S_DONE);
    assign sum   = sum_reg;
    assign c_out = c_out_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: WIDTH=8 directed tests plus an exhaustive
// WIDTH=4 sweep, scoreboarded through per-instance expected-result queues.
// Build with +define+SERIAL_ADD_OVF_EN to also exercise the ovf output.
`timescale 1ns/1ps

module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start4;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;
    logic       ci8, ci4;
    logic       busy8, done8, co8;
    logic       busy4, done4, co4;
    logic [7:0] sum8;
    logic [3:0] sum4;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf8, ovf4;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [9:0] q8[$];   // {ovf, c_out, sum}
    logic [4:0] q4[$];   // {c_out, sum}

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(co8)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(ci4),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(co4)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf4)
`endif
    );

    task automatic test_reset();
        @(negedge clk);
        total_cnt++;
        if ({busy8, done8, co8, sum8} !== 11'd0) $display("FAIL reset8 got=%h exp=0", {busy8, done8, co8, sum8});
        else pass_cnt++;
        total_cnt++;
        if ({busy4, done4, co4, sum4} !== 7'd0) $display("FAIL reset4 got=%h exp=0", {busy4, done4, co4, sum4});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single WIDTH=8 transaction: model pushes expectation, DUT output pops it.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tbv, input logic tci, input bit rel);
        logic [8:0] full;
        logic [7:0] low;
        logic [9:0] exp_v;
        int edges, busy_n;
        bit got;
        @(negedge clk);
        if (rel) rst = 1'b0;
        a8 = ta; b8 = tbv; ci8 = tci; start8 = 1'b1;
        full = {1'b0, ta} + {1'b0, tbv} + {8'd0, tci};
        low  = {1'b0, ta[6:0]} + {1'b0, tbv[6:0]} + {7'd0, tci};
        q8.push_back({low[7] ^ full[8], full});
        @(posedge clk);
        #1 start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
        edges = 0; busy_n = 0; got = 0;
        while (!got && edges < 30) begin
            @(negedge clk);
            edges++;
            if (done8) got = 1;
            else if (busy8) busy_n++;
        end
        total_cnt++;
        if (got !== 1'b1) $display("FAIL done_seen8 got=%0d exp=1", got);
        else pass_cnt++;
        total_cnt++;
        if (edges != 9) $display("FAIL latency8 got=%0d exp=9", edges);
        else pass_cnt++;
        total_cnt++;
        if (busy_n != 8) $display("FAIL busy_cycles8 got=%0d exp=8", busy_n);
        else pass_cnt++;
        total_cnt++;
        if (busy8 !== 1'b0) $display("FAIL busy_done8 got=%b exp=0", busy8);
        else pass_cnt++;
        exp_v = q8.pop_front();
        total_cnt++;
        if ({co8, sum8} !== exp_v[8:0]) $display("FAIL result8 a=%h b=%h ci=%b got=%h exp=%h", ta, tbv, tci, {co8, sum8}, exp_v[8:0]);
        else pass_cnt++;
`ifdef SERIAL_ADD_OVF_EN
        total_cnt++;
        if (ovf8 !== exp_v[9]) $display("FAIL ovf8 a=%h b=%h got=%b exp=%b", ta, tbv, ovf8, exp_v[9]);
        else pass_cnt++;
`endif
        @(negedge clk);
        total_cnt++;
        if ({done8, co8, sum8} !== {1'b0, exp_v[8:0]}) $display("FAIL done_pulse8 got=%h exp=%h", {done8, co8, sum8}, {1'b0, exp_v[8:0]});
        else pass_cnt++;
        $display("tx8 a=%h b=%h ci=%b -> c_out=%b sum=%h latency=%0d", ta, tbv, tci, co8, sum8, edges);
    endtask

    task automatic test_basic();
        run8(8'h0F, 8'h01, 1'b0, 0);
        total_cnt++;
        if ({co8, sum8} !== 9'h010) $display("FAIL basic got=%h exp=010", {co8, sum8});
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        run8(8'hFF, 8'h01, 1'b0, 0);
        total_cnt++;
        if ({co8, sum8} !== 9'h100) $display("FAIL wrap1 got=%h exp=100", {co8, sum8});
        else pass_cnt++;
        run8(8'hFF, 8'hFF, 1'b1, 0);
        total_cnt++;
        if ({co8, sum8} !== 9'h1FF) $display("FAIL wrap2 got=%h exp=1ff", {co8, sum8});
        else pass_cnt++;
    endtask

    task automatic test_mid_start();
        int waited, extra;
        bit got;
        logic [9:0] exp_v;
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; start8 = 1'b1;
        q8.push_back(10'h046);
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(negedge clk);
        a8 = 8'h55; b8 = 8'h55; start8 = 1'b1;
        repeat (2) @(negedge clk);
        start8 = 1'b0;
        got = 0; waited = 0;
        while (!got && waited < 20) begin
            @(negedge clk);
            waited++;
            if (done8) got = 1;
        end
        exp_v = q8.pop_front();
        total_cnt++;
        if (got !== 1'b1) $display("FAIL mid_done_seen got=%0d exp=1", got);
        else pass_cnt++;
        total_cnt++;
        if ({co8, sum8} !== exp_v[8:0]) $display("FAIL mid_result got=%h exp=%h", {co8, sum8}, exp_v[8:0]);
        else pass_cnt++;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        total_cnt++;
        if (extra != 0) $display("FAIL mid_extra_activity got=%0d exp=0", extra);
        else pass_cnt++;
        $display("tx8 a=12 b=34 ci=0 (start re-asserted mid-run) -> c_out=%b sum=%h", co8, sum8);
    endtask

    task automatic test_reset_mid_run();
        int dn;
        @(negedge clk);
        a8 = 8'h9A; b8 = 8'h11; ci8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({busy8, done8, co8, sum8} !== 11'd0) $display("FAIL abort_state got=%h exp=0", {busy8, done8, co8, sum8});
        else pass_cnt++;
        dn = 0;
        @(negedge clk);
        if (done8) dn++;
        total_cnt++;
        if (dn != 0) $display("FAIL abort_no_done got=%0d exp=0", dn);
        else pass_cnt++;
        $display("tx8 a=9a b=11 ci=1 aborted by reset -> c_out=%b sum=%h", co8, sum8);
        run8(8'h01, 8'h02, 1'b0, 1);
        total_cnt++;
        if ({co8, sum8} !== 9'h003) $display("FAIL after_reset got=%h exp=003", {co8, sum8});
        else pass_cnt++;
    endtask

    task automatic test_sweep4();
        bit stable_ok = 1, overlap = 0, pulse_ok = 1, lat_ok = 1, seen_ok = 1;
        logic [4:0] prev, exp_v;
        int edges;
        bit got;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    @(negedge clk);
                    prev = {co4, sum4};
                    a4 = 4'(ia); b4 = 4'(ib); ci4 = 1'(ic); start4 = 1'b1;
                    q4.push_back(5'(ia + ib + ic));
                    @(posedge clk);
                    #1 start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
                    got = 0; edges = 0;
                    while (!got && edges < 15) begin
                        @(negedge clk);
                        edges++;
                        if (busy4 && done4) overlap = 1;
                        if (done4) got = 1;
                        else if ({co4, sum4} !== prev) stable_ok = 0;
                    end
                    if (!got) seen_ok = 0;
                    if (edges != 5) lat_ok = 0;
                    exp_v = q4.pop_front();
                    total_cnt++;
                    if ({co4, sum4} !== exp_v) $display("FAIL sweep4 a=%h b=%h ci=%0d got=%h exp=%h", ia, ib, ic, {co4, sum4}, exp_v);
                    else pass_cnt++;
                    $display("tx4 a=%h b=%h ci=%0d -> c_out=%b sum=%h", ia, ib, ic, co4, sum4);
                    @(negedge clk);
                    if (done4 !== 1'b0 || {co4, sum4} !== exp_v) pulse_ok = 0;
                end
            end
        end
        total_cnt++;
        if (seen_ok !== 1'b1) $display("FAIL sweep4_done_seen got=%b exp=1", seen_ok);
        else pass_cnt++;
        total_cnt++;
        if (lat_ok !== 1'b1) $display("FAIL sweep4_latency got=%b exp=1", lat_ok);
        else pass_cnt++;
        total_cnt++;
        if (stable_ok !== 1'b1) $display("FAIL sweep4_sum_stable got=%b exp=1", stable_ok);
        else pass_cnt++;
        total_cnt++;
        if (overlap !== 1'b0) $display("FAIL sweep4_busy_done got=%b exp=0", overlap);
        else pass_cnt++;
        total_cnt++;
        if (pulse_ok !== 1'b1) $display("FAIL sweep4_done_pulse got=%b exp=1", pulse_ok);
        else pass_cnt++;
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf();
        run8(8'h7F, 8'h01, 1'b0, 0);
        total_cnt++;
        if ({ovf8, co8, sum8} !== 10'h080 + 10'h200) $display("FAIL ovf_7f got=%h exp=280", {ovf8, co8, sum8});
        else pass_cnt++;
        run8(8'hFF, 8'h01, 1'b0, 0);
        total_cnt++;
        if ({ovf8, co8, sum8} !== 10'h100) $display("FAIL ovf_ff got=%h exp=100", {ovf8, co8, sum8});
        else pass_cnt++;
        run8(8'h80, 8'h80, 1'b0, 0);
        total_cnt++;
        if ({ovf8, co8, sum8} !== 10'h300) $display("FAIL ovf_80 got=%h exp=300", {ovf8, co8, sum8});
        else pass_cnt++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        start8 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; ci8 = 1'b0;
        a4 = '0; b4 = '0; ci4 = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_mid_start();
        test_reset_mid_run();
        test_sweep4();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
